// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcodes, issuer state and response entry types
package alu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 6;
  localparam int DEF_TAG_W = 4;
  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR = 6'h25;
  localparam logic [5:0] ALU_SLT = 6'h2A;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] result;
    logic zero;
    logic [DEF_TAG_W-1:0] tag;
  } alu_rsp_t;
endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: first-word-fall-through response buffer with occupancy count
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = alu_rsp_t
) (
  input logic clk,
  input logic reset,
  input logic push,
  input entry_t din,
  input logic pop,
  output logic valid,
  output entry_t head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign head = valid ? mem[rd] : '0;
  assign do_pop = pop && valid;
  assign do_push = push && (count < CW'(DEPTH) || do_pop);
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop) rd <= nxt(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one ALU op at a time and buffers results (self-check under ALU_ISSUER_CHECK_EN)
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int ALU_LAT = 1,
  parameter int RSP_DEPTH = 2,
  parameter int TAG_W = DEF_TAG_W
) (
  input logic clk,
  input logic reset,
  input logic req_valid,
  output logic req_ready,
  input logic [DATA_W-1:0] req_a,
  input logic [DATA_W-1:0] req_b,
  input logic [CTRL_W-1:0] req_ctrl,
  input logic [TAG_W-1:0] req_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input logic [DATA_W-1:0] alu_result,
  input logic alu_zero,
  output logic rsp_valid,
  input logic rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic busy,
  output logic chk_err
);
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic zero;
    logic [TAG_W-1:0] tag;
  } rsp_t;
  localparam int CW = $clog2(RSP_DEPTH+1);
  state_t state;
  logic [2:0] cnt;
  logic [TAG_W-1:0] tag;
  logic capture, stage_valid;
  rsp_t stage, head;
  logic [CW-1:0] count;
  assign capture = state == WAIT && cnt == '0;
  assign busy = state != IDLE;
  assign req_ready = state == IDLE && ({1'b0, count} + (CW+1)'(stage_valid)) < (CW+1)'(RSP_DEPTH);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tag <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_control <= '0;
      stage_valid <= 1'b0;
      stage <= '0;
    end else begin
      stage_valid <= capture;
      if (capture) stage <= '{result: alu_result, zero: alu_zero, tag: tag};
      if (state == IDLE && req_valid && req_ready) begin
        alu_a <= req_a;
        alu_b <= req_b;
        alu_control <= req_ctrl;
        tag <= req_tag;
        cnt <= 3'(ALU_LAT);
        state <= WAIT;
      end else if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - 3'd1;
        else state <= IDLE;
      end
    end
  end
  alu_rsp_fifo #(.DEPTH(RSP_DEPTH), .entry_t(rsp_t)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(stage_valid),
    .din(stage),
    .pop(rsp_ready),
    .valid(rsp_valid),
    .head(head),
    .count(count)
  );
  assign rsp_result = head.result;
  assign rsp_zero = head.zero;
  assign rsp_tag = head.tag;
`ifdef ALU_ISSUER_CHECK_EN
  logic [DATA_W-1:0] expected;
  logic known, bad;
  always_comb begin
    known = alu_control inside {CTRL_W'(ALU_ADD), CTRL_W'(ALU_SUB), CTRL_W'(ALU_AND), CTRL_W'(ALU_OR), CTRL_W'(ALU_SLT)};
    expected = alu_control == CTRL_W'(ALU_ADD) ? alu_a + alu_b :
               alu_control == CTRL_W'(ALU_SUB) ? alu_a - alu_b :
               alu_control == CTRL_W'(ALU_AND) ? alu_a & alu_b :
               alu_control == CTRL_W'(ALU_OR) ? alu_a | alu_b :
               alu_control == CTRL_W'(ALU_SLT) ? DATA_W'($signed(alu_a) < $signed(alu_b)) : '0;
  end
  assign bad = known && (alu_result != expected || alu_zero != (expected == '0));
  always_ff @(posedge clk) begin
    chk_err <= reset ? 1'b0 : chk_err | (capture && bad);
  end
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Requester side of the ALU interface. It accepts operation requests on a valid/ready port, drives the ALU's a, b and alu_control inputs, waits a fixed ALU latency, and captures result and zero.
- Captured results are returned through a small buffered valid/ready response port.
- It sits between the datapath or test sequencer and the ALU, and allows one operation in flight.

Parameters:
- DATA_W, 32, operand and result width
- CTRL_W, 6, alu_control width
- ALU_LAT, 1, cycles from ALU inputs changing to a stable result, legal range 0..4 (0 = combinational ALU)
- RSP_DEPTH, 2, response buffer entries, legal range 1..4
- TAG_W, 4, request tag width

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_a  in  DATA_W  operand a
- req_b  in  DATA_W  operand b
- req_ctrl  in  CTRL_W  operation select
- req_tag  in  TAG_W  tag returned with the response
- alu_a  out  DATA_W  registered operand to the ALU
- alu_b  out  DATA_W  registered operand to the ALU
- alu_control  out  CTRL_W  registered operation select to the ALU
- alu_result  in  DATA_W  ALU result
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response buffer not empty
- rsp_ready  in  1  consumer pops the head entry
- rsp_result  out  DATA_W  head entry result
- rsp_zero  out  1  head entry zero flag
- rsp_tag  out  TAG_W  head entry tag
- busy  out  1  state != IDLE
- chk_err  out  1  sticky check error (see Optional Feature)

Behaviour:
- Reset, when reset is high at a clk edge:
  - state = IDLE, counter = 0, buffer empty.
  - alu_a, alu_b, alu_control = 0; rsp_valid = 0; rsp_result, rsp_zero, rsp_tag = 0; busy = 0; chk_err = 0.
  - Reset mid-operation discards the in-flight operation and all buffered responses.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - req_ready = (buffer count < RSP_DEPTH), computed combinationally from registered state.
  - On req_valid && req_ready:
    - register req_a, req_b, req_ctrl into alu_a, alu_b, alu_control;
    - latch req_tag;
    - cnt = ALU_LAT;
    - go to WAIT.
- WAIT:
  - req_ready = 0.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: sample alu_result and alu_zero, push {result, zero, tag} into the buffer, go to IDLE.
- ALU inputs hold their last value after capture until the next accept.
- Latency: the accept edge to the rsp_valid-high edge is ALU_LAT+2 cycles when the buffer was empty. Maximum throughput is one op per ALU_LAT+2 cycles.
- Buffer: FIFO, first-word-fall-through.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop leave the count unchanged.
  - Pop when empty is ignored.
- Space is guaranteed at capture: an op is accepted only with count < RSP_DEPTH, and the count cannot grow while in WAIT.
- Back-to-back requests: the next request can be accepted on the cycle after capture, because state returns to IDLE at the capture edge.
- req_* inputs are don't-care unless req_valid is high. Request fields may change while req_ready is low.

Optional Feature:
- Macro: ALU_ISSUER_CHECK_EN.
- When defined, the block computes the expected result of each op from the latched operands and opcode at capture. Checked opcodes: ADD, SUB, AND, OR, SLT (signed).
- chk_err sets if alu_result != expected, or alu_zero != (expected == 0).
- chk_err is sticky until reset. Unknown opcodes are not checked.
- When not defined, the checker logic is absent and chk_err is tied to 0.

Decomposition:
- Package alu_pkg:
  - DATA_W and CTRL_W defaults;
  - opcode constants ALU_ADD=6'h20, ALU_SUB=6'h22, ALU_AND=6'h24, ALU_OR=6'h25, ALU_SLT=6'h2A;
  - state enum typedef {IDLE, WAIT};
  - packed struct alu_rsp_t {result, zero, tag}.
- Sub-module alu_rsp_fifo (parameterised depth, alu_rsp_t entries, count output) holds the response buffer.

Test Plan:
- Reset, then ADD a=5 b=7 tag=3 with ALU_LAT=1 -> alu_a=5 on the cycle after accept; rsp_valid 3 cycles after the accept edge; rsp_result=12, zero=0, tag=3.
- SUB a=9 b=9 -> rsp_result=0, rsp_zero=1. SLT a=32'hFFFFFFFF b=1 -> rsp_result=1.
- rsp_ready held 0 with RSP_DEPTH=2, issue 3 requests -> the first two complete, then req_ready stays 0; one pop -> third request accepted; responses come out in tag order.
- Pop and push on the same edge with count=1 -> count stays 1, correct head ordering.
- Assert reset while in WAIT -> next cycle busy=0, rsp_valid=0, alu_* = 0; a new request completes normally afterwards.
- ALU_ISSUER_CHECK_EN defined, ALU model forces wrong result for AND a=8'hF0 b=8'h3C -> chk_err=1 at the capture edge and stays 1; chk_err stays 0 for correct ops and for opcode 6'h00.
